// File: rtl/tomasulo_regs_cdb_jump_if.sv
// Bus bundle for the Tomasulo front-end: issue/rename, register read ports,
// CDB request/grant/broadcast and jump resolver signals.
interface tomasulo_regs_cdb_jump_if #(
    parameter int TAG_W = 8,
    parameter int XLEN  = 32,
    parameter int AW    = 5
);
    logic                  i_issue;
    logic [AW-1:0]         i_waddr;
    logic [TAG_W-1:0]      i_w_tag;
    logic [AW-1:0]         i_raddr_a;
    logic [AW-1:0]         i_raddr_b;
    logic [TAG_W+XLEN-1:0] o_rdata_a;
    logic [TAG_W+XLEN-1:0] o_rdata_b;

    logic                  i_alu_req;
    logic                  i_mul_req;
    logic                  i_div_req;
    logic                  i_ls_req;
    logic [TAG_W+XLEN-1:0] i_alu_in;
    logic [TAG_W+XLEN-1:0] i_mul_in;
    logic [TAG_W+XLEN-1:0] i_div_in;
    logic [TAG_W+XLEN-1:0] i_ls_in;
    logic                  o_alu_gnt;
    logic                  o_mul_gnt;
    logic                  o_div_gnt;
    logic                  o_ls_gnt;
    logic [TAG_W+XLEN:0]   o_cdb;

    logic                  i_branch_issue;
    logic                  i_ujump_issue;
    logic [3:0]            i_jump_op;
    logic [XLEN-1:0]       i_imm;
    logic [XLEN-1:0]       i_pc;
    logic [XLEN-1:0]       o_pc_jump;
    logic [XLEN-1:0]       o_pcp4;
    logic                  o_to_jump;
    logic                  o_jump_stall;

    modport slave (
        input  i_issue, i_waddr, i_w_tag, i_raddr_a, i_raddr_b,
        output o_rdata_a, o_rdata_b,
        input  i_alu_req, i_mul_req, i_div_req, i_ls_req,
        input  i_alu_in, i_mul_in, i_div_in, i_ls_in,
        output o_alu_gnt, o_mul_gnt, o_div_gnt, o_ls_gnt, o_cdb,
        input  i_branch_issue, i_ujump_issue, i_jump_op, i_imm, i_pc,
        output o_pc_jump, o_pcp4, o_to_jump, o_jump_stall
    );

    modport master (
        output i_issue, i_waddr, i_w_tag, i_raddr_a, i_raddr_b,
        input  o_rdata_a, o_rdata_b,
        output i_alu_req, i_mul_req, i_div_req, i_ls_req,
        output i_alu_in, i_mul_in, i_div_in, i_ls_in,
        input  o_alu_gnt, o_mul_gnt, o_div_gnt, o_ls_gnt, o_cdb,
        output i_branch_issue, i_ujump_issue, i_jump_op, i_imm, i_pc,
        input  o_pc_jump, o_pcp4, o_to_jump, o_jump_stall
    );
endinterface

// File: rtl/tomasulo_regs_cdb_jump.sv
// Tomasulo front-end: tagged register file with CDB bypass, fixed-priority
// registered CDB arbiter, and a jump/branch resolver that stalls on pending operands.
module tomasulo_regs_cdb_jump #(
    parameter int NREGS = 32,
    parameter int TAG_W = 8,
    parameter int XLEN  = 32,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    tomasulo_regs_cdb_jump_if.slave   bus
);
    localparam int EW = TAG_W + XLEN;

    logic [TAG_W-1:0] r_tag  [NREGS];
    logic [XLEN-1:0]  r_data [NREGS];
    logic             r_cdb_valid;
    logic [TAG_W-1:0] r_cdb_tag;
    logic [XLEN-1:0]  r_cdb_data;

    logic [3:0]       w_gnt;
    logic [EW-1:0]    w_win;
    logic             w_cdb_hit;
    logic [EW-1:0]    w_rdata_a;
    logic [EW-1:0]    w_rdata_b;
    logic             w_uj;
    logic             w_br;
    logic             w_is_jal;
    logic             w_rdy1;
    logic             w_rdy2;
    logic             w_need1;
    logic             w_need2;
    logic             w_stall;
    logic             w_cond;
    logic             w_ujump_wb;
    logic [XLEN-1:0]  w_rs1;
    logic [XLEN-1:0]  w_rs2;
    logic [XLEN-1:0]  w_pcp4;
    logic [XLEN-1:0]  w_target;

    // Fixed priority: ALU > mul > div > ls
    always_comb begin
        w_gnt = 4'b0000;
        w_win = '0;
        if (bus.i_alu_req) begin
            w_gnt[0] = 1'b1;
            w_win    = bus.i_alu_in;
        end else if (bus.i_mul_req) begin
            w_gnt[1] = 1'b1;
            w_win    = bus.i_mul_in;
        end else if (bus.i_div_req) begin
            w_gnt[2] = 1'b1;
            w_win    = bus.i_div_in;
        end else if (bus.i_ls_req) begin
            w_gnt[3] = 1'b1;
            w_win    = bus.i_ls_in;
        end
    end

    assign bus.o_alu_gnt = w_gnt[0];
    assign bus.o_mul_gnt = w_gnt[1];
    assign bus.o_div_gnt = w_gnt[2];
    assign bus.o_ls_gnt  = w_gnt[3];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cdb_valid <= 1'b0;
            r_cdb_tag   <= '0;
            r_cdb_data  <= '0;
        end else begin
            r_cdb_valid <= |w_gnt;
            r_cdb_tag   <= w_win[EW-1:XLEN];
            r_cdb_data  <= w_win[XLEN-1:0];
        end
    end

    assign bus.o_cdb = {r_cdb_valid, r_cdb_tag, r_cdb_data};
    assign w_cdb_hit = r_cdb_valid && (r_cdb_tag != '0);

    function automatic logic [EW-1:0] read_port(input logic [AW-1:0] addr);
        logic [EW-1:0] val;
        if (addr == '0) begin
            val = '0;
        end else if (w_cdb_hit && (r_tag[addr] == r_cdb_tag)) begin
            val = {{TAG_W{1'b0}}, r_cdb_data};
        end else begin
            val = {r_tag[addr], r_data[addr]};
        end
        return val;
    endfunction

    assign w_rdata_a     = read_port(bus.i_raddr_a);
    assign w_rdata_b     = read_port(bus.i_raddr_b);
    assign bus.o_rdata_a = w_rdata_a;
    assign bus.o_rdata_b = w_rdata_b;

    // Operands come through the bypassed read ports, so tag 0 already means ready.
    assign w_rs1  = w_rdata_a[XLEN-1:0];
    assign w_rs2  = w_rdata_b[XLEN-1:0];
    assign w_rdy1 = (w_rdata_a[EW-1:XLEN] == '0);
    assign w_rdy2 = (w_rdata_b[EW-1:XLEN] == '0);

    assign w_uj     = bus.i_ujump_issue;
    assign w_br     = bus.i_branch_issue & ~bus.i_ujump_issue;
    assign w_is_jal = (bus.i_jump_op == 4'b1001);
    assign w_need1  = (w_uj & ~w_is_jal) | w_br;
    assign w_need2  = w_br;
    assign w_stall  = (w_uj | w_br) & ((w_need1 & ~w_rdy1) | (w_need2 & ~w_rdy2));

    always_comb begin
        w_cond = 1'b0;
        case (bus.i_jump_op[2:0])
            3'b000:  w_cond = (w_rs1 == w_rs2);
            3'b001:  w_cond = (w_rs1 != w_rs2);
            3'b100:  w_cond = ($signed(w_rs1) <  $signed(w_rs2));
            3'b101:  w_cond = ($signed(w_rs1) >= $signed(w_rs2));
            3'b110:  w_cond = (w_rs1 <  w_rs2);
            3'b111:  w_cond = (w_rs1 >= w_rs2);
            default: w_cond = 1'b0;
        endcase
    end

    assign w_pcp4   = bus.i_pc + XLEN'(4);
    assign w_target = (w_uj & ~w_is_jal) ? ((w_rs1 + bus.i_imm) & ~XLEN'(1))
                                         : (bus.i_pc + bus.i_imm);

    assign bus.o_pcp4       = w_pcp4;
    assign bus.o_pc_jump    = w_target;
    assign bus.o_jump_stall = w_stall;
    assign bus.o_to_jump    = ~w_stall & (w_uj | (w_br & w_cond));
    assign w_ujump_wb       = w_uj & ~w_stall;

    // Later assignments win: CDB clear, then issue rename, then link writeback.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                r_tag[i]  <= '0;
                r_data[i] <= '0;
            end
        end else begin
            for (int i = 1; i < NREGS; i++) begin
                if (w_cdb_hit && (r_tag[i] == r_cdb_tag)) begin
                    r_data[i] <= r_cdb_data;
                    r_tag[i]  <= '0;
                end
                if (bus.i_issue && (bus.i_waddr == AW'(i))) begin
                    r_tag[i] <= bus.i_w_tag;
                end
                if (w_ujump_wb && (bus.i_waddr == AW'(i))) begin
                    r_tag[i]  <= '0;
                    r_data[i] <= w_pcp4;
                end
            end
        end
    end
endmodule

// File: tb/tb_tomasulo_regs_cdb_jump.sv
// Directed spec scenarios followed by randomized traffic, checked against a
// behavioural register/CDB/jump model held in the bench.
module tb_tomasulo_regs_cdb_jump;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    tomasulo_regs_cdb_jump_if bus();

    tomasulo_regs_cdb_jump dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_assert = 0;
    int n_fail   = 0;

    logic [7:0]  m_tag  [32];
    logic [31:0] m_data [32];
    logic        m_cv;
    logic [7:0]  m_ctag;
    logic [31:0] m_cdata;

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_tag[i]  = 8'h0;
            m_data[i] = 32'h0;
        end
        m_cv    = 1'b0;
        m_ctag  = 8'h0;
        m_cdata = 32'h0;
    endtask

    function automatic logic [39:0] exp_read(input logic [4:0] a);
        if (a == 5'd0) return 40'h0;
        if (m_cv && m_ctag != 8'h0 && m_tag[a] == m_ctag) return {8'h0, m_cdata};
        return {m_tag[a], m_data[a]};
    endfunction

    function automatic logic [3:0] exp_gnt();
        logic [3:0] r;
        r = {bus.i_ls_req, bus.i_div_req, bus.i_mul_req, bus.i_alu_req};
        for (int i = 0; i < 4; i++)
            if (r[i]) return 4'(1 << i);
        return 4'h0;
    endfunction

    task automatic jump_model(output logic stall, output logic tj, output logic [31:0] tgt);
        logic [39:0] a, b;
        logic uj, br, jal, rdy1, rdy2, c;
        a    = exp_read(bus.i_raddr_a);
        b    = exp_read(bus.i_raddr_b);
        uj   = bus.i_ujump_issue;
        br   = bus.i_branch_issue && !uj;
        jal  = (bus.i_jump_op == 4'd9);
        rdy1 = (a[39:32] == 8'h0);
        rdy2 = (b[39:32] == 8'h0);
        if (uj)      stall = jal ? 1'b0 : !rdy1;
        else if (br) stall = !(rdy1 && rdy2);
        else         stall = 1'b0;
        case (bus.i_jump_op[2:0])
            3'd0:    c = (a[31:0] == b[31:0]);
            3'd1:    c = (a[31:0] != b[31:0]);
            3'd4:    c = ($signed(a[31:0]) <  $signed(b[31:0]));
            3'd5:    c = ($signed(a[31:0]) >= $signed(b[31:0]));
            3'd6:    c = (a[31:0] <  b[31:0]);
            3'd7:    c = (a[31:0] >= b[31:0]);
            default: c = 1'b0;
        endcase
        tgt = (uj && !jal) ? ((a[31:0] + bus.i_imm) & 32'hFFFF_FFFE) : (bus.i_pc + bus.i_imm);
        tj  = !stall && (uj || (br && c));
    endtask

    task automatic check_outputs();
        logic stall, tj;
        logic [31:0] tgt;
        jump_model(stall, tj, tgt);
        chk("rdata_a", bus.o_rdata_a, exp_read(bus.i_raddr_a));
        chk("rdata_b", bus.o_rdata_b, exp_read(bus.i_raddr_b));
        chk("cdb", bus.o_cdb, {m_cv, m_ctag, m_cdata});
        chk("gnt", {bus.o_ls_gnt, bus.o_div_gnt, bus.o_mul_gnt, bus.o_alu_gnt}, exp_gnt());
        chk("pcp4", bus.o_pcp4, bus.i_pc + 32'd4);
        chk("jump_stall", bus.o_jump_stall, stall);
        chk("to_jump", bus.o_to_jump, tj);
        if (tj) chk("pc_jump", bus.o_pc_jump, tgt);
    endtask

    task automatic model_update();
        logic stall, tj;
        logic [31:0] tgt;
        logic [7:0]  nt [32];
        logic [31:0] nd [32];
        logic [3:0]  req;
        logic [39:0] ins [4];
        jump_model(stall, tj, tgt);
        for (int i = 0; i < 32; i++) begin
            nt[i] = m_tag[i];
            nd[i] = m_data[i];
        end
        if (m_cv && m_ctag != 8'h0)
            for (int i = 1; i < 32; i++)
                if (m_tag[i] == m_ctag) begin
                    nd[i] = m_cdata;
                    nt[i] = 8'h0;
                end
        if (bus.i_issue && bus.i_waddr != 5'd0) nt[bus.i_waddr] = bus.i_w_tag;
        if (bus.i_ujump_issue && !stall && bus.i_waddr != 5'd0) begin
            nt[bus.i_waddr] = 8'h0;
            nd[bus.i_waddr] = bus.i_pc + 32'd4;
        end
        for (int i = 0; i < 32; i++) begin
            m_tag[i]  = nt[i];
            m_data[i] = nd[i];
        end
        req = {bus.i_ls_req, bus.i_div_req, bus.i_mul_req, bus.i_alu_req};
        ins = '{bus.i_alu_in, bus.i_mul_in, bus.i_div_in, bus.i_ls_in};
        {m_cv, m_ctag, m_cdata} = 41'h0;
        for (int i = 3; i >= 0; i--)
            if (req[i]) {m_cv, m_ctag, m_cdata} = {1'b1, ins[i]};
    endtask

    task automatic step();
        @(negedge clk);
        check_outputs();
        @(posedge clk);
        model_update();
        #1;
    endtask

    initial begin
        bus.i_issue = 0; bus.i_waddr = 0; bus.i_w_tag = 0;
        bus.i_raddr_a = 5'd3; bus.i_raddr_b = 5'd4;
        bus.i_alu_req = 0; bus.i_mul_req = 0; bus.i_div_req = 0; bus.i_ls_req = 0;
        bus.i_alu_in = 0; bus.i_mul_in = 0; bus.i_div_in = 0; bus.i_ls_in = 0;
        bus.i_branch_issue = 0; bus.i_ujump_issue = 0; bus.i_jump_op = 0;
        bus.i_imm = 0; bus.i_pc = 0;
        model_reset();
        #1 rst_n = 1'b0;
        #10;
        chk("rst_rdata_a", bus.o_rdata_a, 40'h0);
        chk("rst_rdata_b", bus.o_rdata_b, 40'h0);
        chk("rst_cdb", bus.o_cdb, 41'h0);
        chk("rst_to_jump", bus.o_to_jump, 1'b0);
        chk("rst_stall", bus.o_jump_stall, 1'b0);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // Rename r1 twice and r2 once
        bus.i_raddr_a = 5'd1; bus.i_raddr_b = 5'd2;
        bus.i_issue = 1; bus.i_waddr = 5'd1; bus.i_w_tag = 8'h81; step();
        bus.i_w_tag = 8'h82; step();
        bus.i_waddr = 5'd2; bus.i_w_tag = 8'h84; step();
        bus.i_issue = 0;
        #1;
        chk("t2_rdata_a", bus.o_rdata_a, 40'h82_0000_0000);
        chk("t2_rdata_b", bus.o_rdata_b, 40'h84_0000_0000);

        // JALR on pending rs1 stalls
        bus.i_ujump_issue = 1; bus.i_jump_op = 4'b1000;
        bus.i_pc = 32'hC0; bus.i_imm = 32'hA6; bus.i_waddr = 5'd2;
        #1;
        chk("t3_stall", bus.o_jump_stall, 1'b1);
        chk("t3_to_jump", bus.o_to_jump, 1'b0);
        step();
        chk("t3_reg2", bus.o_rdata_b, 40'h84_0000_0000);

        // ALU broadcast releases the stall via bypass
        bus.i_alu_req = 1; bus.i_alu_in = 40'h82_0000_0048;
        #1;
        chk("t4_alu_gnt", bus.o_alu_gnt, 1'b1);
        step();
        bus.i_alu_req = 0;
        #1;
        chk("t4_cdb", bus.o_cdb, 41'h1_82_0000_0048);
        chk("t4_rdata_a", bus.o_rdata_a, 40'h00_0000_0048);
        chk("t4_stall", bus.o_jump_stall, 1'b0);
        chk("t4_to_jump", bus.o_to_jump, 1'b1);
        chk("t4_pc_jump", bus.o_pc_jump, 32'hEE);
        step();
        bus.i_ujump_issue = 0;
        #1;
        chk("t4_reg1", bus.o_rdata_a, 40'h00_0000_0048);
        chk("t4_reg2", bus.o_rdata_b, 40'h00_0000_00C4);

        // ALU and mul collide
        bus.i_alu_req = 1; bus.i_alu_in = 40'h11_0000_0001;
        bus.i_mul_req = 1; bus.i_mul_in = 40'h12_0000_0002;
        #1;
        chk("t5_gnt_first", {bus.o_mul_gnt, bus.o_alu_gnt}, 2'b01);
        step();
        bus.i_alu_req = 0;
        #1;
        chk("t5_cdb_alu", bus.o_cdb, 41'h1_11_0000_0001);
        chk("t5_gnt_second", {bus.o_mul_gnt, bus.o_alu_gnt}, 2'b10);
        step();
        bus.i_mul_req = 0;
        #1;
        chk("t5_cdb_mul", bus.o_cdb, 41'h1_12_0000_0002);
        step();
        chk("t5_cdb_idle", bus.o_cdb, 41'h0);

        // Make r5 ready, then BEQ / BNE on r5,r5
        bus.i_issue = 1; bus.i_waddr = 5'd5; bus.i_w_tag = 8'h10; step();
        bus.i_issue = 0;
        bus.i_alu_req = 1; bus.i_alu_in = 40'h10_1234_5678; step();
        bus.i_alu_req = 0; step();
        bus.i_raddr_a = 5'd5; bus.i_raddr_b = 5'd5;
        bus.i_branch_issue = 1; bus.i_jump_op = 4'b0000; bus.i_imm = 32'h8; bus.i_pc = 32'h100;
        #1;
        chk("t6_beq_to_jump", bus.o_to_jump, 1'b1);
        chk("t6_beq_pc_jump", bus.o_pc_jump, 32'h108);
        bus.i_jump_op = 4'b0001;
        #1;
        chk("t6_bne_to_jump", bus.o_to_jump, 1'b0);
        step();
        bus.i_branch_issue = 0;

        // x0 ignores renames
        bus.i_issue = 1; bus.i_waddr = 5'd0; bus.i_w_tag = 8'h55; step();
        bus.i_issue = 0; bus.i_raddr_a = 5'd0;
        #1;
        chk("x0_read", bus.o_rdata_a, 40'h0);

        for (int k = 0; k < 600; k++) begin
            bus.i_issue   = ($urandom % 3) == 0;
            bus.i_waddr   = 5'($urandom % 8);
            bus.i_w_tag   = 8'($urandom_range(1, 15));
            bus.i_raddr_a = 5'($urandom % 8);
            bus.i_raddr_b = 5'($urandom % 8);
            bus.i_alu_req = ($urandom % 3) == 0;
            bus.i_mul_req = ($urandom % 3) == 0;
            bus.i_div_req = ($urandom % 3) == 0;
            bus.i_ls_req  = ($urandom % 3) == 0;
            bus.i_alu_in  = {m_tag[$urandom % 8], 32'($urandom % 16)};
            bus.i_mul_in  = {m_tag[$urandom % 8], $urandom};
            bus.i_div_in  = {8'($urandom_range(0, 15)), 32'($urandom % 16)};
            bus.i_ls_in   = {m_tag[$urandom % 8], $urandom};
            bus.i_branch_issue = ($urandom % 4) == 0;
            bus.i_ujump_issue  = ($urandom % 6) == 0;
            if (bus.i_ujump_issue) bus.i_jump_op = {3'b100, 1'($urandom % 2)};
            else                   bus.i_jump_op = {1'b0, 3'($urandom % 8)};
            bus.i_imm = $urandom;
            bus.i_pc  = $urandom;
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
